// File: rtl/aes_inv_addkey_mc_serial_pkg.sv
// Shared AES datapath widths, FSM state type and GF(2^8) helper for the
// column-serial inverse round stage.
package aes_inv_addkey_mc_serial_pkg;

  localparam int AES_NCOLS   = 4;
  localparam int AES_COL_W   = 32;
  localparam int AES_BYTE_W  = 8;
  localparam int AES_STATE_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROC = 2'd1,
    DONE = 2'd2
  } fsm_state_e;

  // Multiply by x in GF(2^8) modulo 0x11b.
  function automatic logic [AES_BYTE_W-1:0] xtime(input logic [AES_BYTE_W-1:0] b);
    return {b[AES_BYTE_W-2:0], 1'b0} ^ (b[AES_BYTE_W-1] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_mc_single_column_inverse.sv
// Combinational inverse MixColumns on one 32-bit column; row r lives in
// bits [8r+:8].
module aes_mc_single_column_inverse
  import aes_inv_addkey_mc_serial_pkg::*;
(
  input  logic [AES_COL_W-1:0] cin,
  output logic [AES_COL_W-1:0] cout
);

  logic [AES_BYTE_W-1:0] x  [4];
  logic [AES_BYTE_W-1:0] x2 [4];
  logic [AES_BYTE_W-1:0] x4 [4];
  logic [AES_BYTE_W-1:0] x8 [4];
  logic [AES_BYTE_W-1:0] m9 [4];
  logic [AES_BYTE_W-1:0] mb [4];
  logic [AES_BYTE_W-1:0] md [4];
  logic [AES_BYTE_W-1:0] me [4];

  // 09/0b/0d/0e are built from the shared x2/x4/x8 doubling chain.
  always_comb begin
    for (int unsigned r = 0; r < 4; r++) begin
      x[r]  = cin[r*AES_BYTE_W +: AES_BYTE_W];
      x2[r] = xtime(x[r]);
      x4[r] = xtime(x2[r]);
      x8[r] = xtime(x4[r]);
      m9[r] = x8[r] ^ x[r];
      mb[r] = x8[r] ^ x2[r] ^ x[r];
      md[r] = x8[r] ^ x4[r] ^ x[r];
      me[r] = x8[r] ^ x4[r] ^ x2[r];
    end
    cout = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      cout[r*AES_BYTE_W +: AES_BYTE_W] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
    end
  end

endmodule

// File: rtl/aes_inv_addkey_mc_serial.sv
// Decryption round stage: AddRoundKey on accept, then inverse MixColumns
// one column per cycle through a single shared column datapath.
module aes_inv_addkey_mc_serial
  import aes_inv_addkey_mc_serial_pkg::*;
#(
  parameter int NCOLS = AES_NCOLS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_state,
  input  logic [AES_STATE_W-1:0] in_key,
  input  logic                   in_bypass_mc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state
);

  localparam int CNT_W = $clog2(NCOLS);

  fsm_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [AES_STATE_W-1:0] buf_q, buf_d;
  logic [AES_COL_W-1:0]   col_in, col_out;
  logic [NCOLS-1:0]       col_en;

  always_comb begin
    col_in = '0;
    for (int unsigned c = 0; c < NCOLS; c++) begin
      if (cnt_q == CNT_W'(c)) col_in = buf_q[c*AES_COL_W +: AES_COL_W];
    end
    col_en = (state_q == PROC) ? (NCOLS'(1) << cnt_q) : '0;
  end

  aes_mc_single_column_inverse u_inv_mc (
    .cin  (col_in),
    .cout (col_out)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          buf_d   = in_state ^ in_key;
          cnt_d   = '0;
          state_d = in_bypass_mc ? DONE : PROC;
        end
      end
      PROC: begin
        for (int unsigned c = 0; c < NCOLS; c++) begin
          if (col_en[c]) buf_d[c*AES_COL_W +: AES_COL_W] = col_out;
        end
        if (cnt_q == CNT_W'(NCOLS-1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_state = buf_q;

endmodule

// File: tb/tb_aes_inv_addkey_mc_serial.sv
// Scoreboard bench for the column-serial AddRoundKey + inverse MixColumns stage.
module tb_aes_inv_addkey_mc_serial;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic [127:0] in_key;
  logic         in_bypass_mc;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  int checks   = 0;
  int failures = 0;
  logic [127:0] sb[$];

  aes_inv_addkey_mc_serial #(.NCOLS(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_state     (in_state),
    .in_key       (in_key),
    .in_bypass_mc (in_bypass_mc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_state    (out_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic [127:0] k,
                                         input logic byp);
    logic [127:0] t = s ^ k;
    logic [7:0] x0, x1, x2, x3;
    if (byp) return t;
    for (int c = 0; c < 4; c++) begin
      x0 = t[32*c +: 8];
      x1 = t[32*c + 8 +: 8];
      x2 = t[32*c + 16 +: 8];
      x3 = t[32*c + 24 +: 8];
      t[32*c +: 8]      = gmul(x0, 8'h0e) ^ gmul(x1, 8'h0b) ^ gmul(x2, 8'h0d) ^ gmul(x3, 8'h09);
      t[32*c + 8 +: 8]  = gmul(x0, 8'h09) ^ gmul(x1, 8'h0e) ^ gmul(x2, 8'h0b) ^ gmul(x3, 8'h0d);
      t[32*c + 16 +: 8] = gmul(x0, 8'h0d) ^ gmul(x1, 8'h09) ^ gmul(x2, 8'h0e) ^ gmul(x3, 8'h0b);
      t[32*c + 24 +: 8] = gmul(x0, 8'h0b) ^ gmul(x1, 8'h0d) ^ gmul(x2, 8'h09) ^ gmul(x3, 8'h0e);
    end
    return t;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offers one transfer, returns whether it was accepted, and scrambles the
  // data inputs after the accepting edge.
  task automatic send(input logic [127:0] s, input logic [127:0] k, input logic byp,
                      output logic accepted);
    int w = 0;
    in_state = s; in_key = k; in_bypass_mc = byp; in_valid = 1'b1;
    while (!in_ready && w < 20) begin tick; w++; end
    accepted = in_ready;
    tick;
    if (accepted) sb.push_back(model(s, k, byp));
    in_valid = 1'b0;
    in_state = ~s;
    in_key = {$urandom, $urandom, $urandom, $urandom};
    in_bypass_mc = ~byp;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin tick; lat++; end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_state = '0; in_key = '0; in_bypass_mc = 1'b0;
    tick; tick;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_state !== '0) begin
      failures++;
      $display("FAIL reset: in_ready=%b out_valid=%b out_state=%h, required 1 0 0",
               in_ready, out_valid, out_state);
    end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_reset_mid_proc;
    logic acc;
    int seen = 0;
    send(128'h1234, 128'h5678, 1'b0, acc);
    if (acc) void'(sb.pop_back());
    tick;
    rst_n = 1'b0;
    tick;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_state !== '0) begin
      failures++;
      $display("FAIL reset_mid_proc: in_ready=%b out_valid=%b out_state=%h, required 1 0 0",
               in_ready, out_valid, out_state);
    end
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen++;
      tick;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_no_output: out_valid cycles=%0d, required 0", seen);
    end
  endtask

  task automatic run_one(input string name, input logic [127:0] s, input logic [127:0] k,
                         input logic byp, input int exp_lat);
    logic acc;
    int lat;
    logic [127:0] exp;
    out_ready = 1'b1;
    send(s, k, byp, acc);
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL %s_accept: in_ready never rose", name);
      return;
    end
    wait_valid(lat);
    checks++;
    if (lat != exp_lat || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_latency: got %0d edges (valid=%b), required %0d", name, lat, out_valid, exp_lat);
    end
    exp = sb.pop_front();
    checks++;
    if (out_state !== exp) begin
      failures++;
      $display("FAIL %s_data: got %h, required %h", name, out_state, exp);
    end
    tick;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_release: in_ready=%b out_valid=%b, required 1 0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_known_column;
    run_one("known_col", {96'h01010101_01010101_01010101, 32'hbca14d8e}, '0, 1'b0, 4);
    checks++;
    if (out_state !== '0 && sb.size() != 0) begin
      failures++;
      $display("FAIL known_col_sb: leftover entries=%0d, required 0", sb.size());
    end
  endtask

  task automatic test_known_column_const;
    logic acc;
    int lat;
    out_ready = 1'b1;
    send({96'h01010101_01010101_01010101, 32'hbca14d8e}, '0, 1'b0, acc);
    wait_valid(lat);
    void'(sb.pop_front());
    checks++;
    if (out_state !== {96'h01010101_01010101_01010101, 32'h455313db}) begin
      failures++;
      $display("FAIL known_col_const: got %h, required %h", out_state,
               {96'h01010101_01010101_01010101, 32'h455313db});
    end
    tick;
  endtask

  task automatic test_addkey_mc;
    logic acc;
    int lat;
    out_ready = 1'b1;
    send('0, {96'h0, 32'hd6d7d5d5}, 1'b0, acc);
    wait_valid(lat);
    void'(sb.pop_front());
    checks++;
    if (out_state !== {96'h0, 32'hd5d4d4d4} || lat != 4) begin
      failures++;
      $display("FAIL addkey_mc: got %h lat=%0d, required %h lat=4", out_state, lat,
               {96'h0, 32'hd5d4d4d4});
    end
    tick;
  endtask

  task automatic test_bypass;
    logic acc;
    int lat;
    out_ready = 1'b1;
    send(128'h0123456789abcdeffedcba9876543210, '1, 1'b1, acc);
    wait_valid(lat);
    void'(sb.pop_front());
    checks++;
    if (out_state !== 128'hfedcba98765432100123456789abcdef || lat != 0) begin
      failures++;
      $display("FAIL bypass: got %h lat=%0d, required fedcba98765432100123456789abcdef lat=0",
               out_state, lat);
    end
    tick;
  endtask

  task automatic test_random;
    for (int i = 0; i < 6; i++) begin
      logic byp = 1'($urandom_range(0, 1));
      run_one("random", {$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom}, byp, byp ? 0 : 4);
    end
  endtask

  task automatic test_backpressure;
    logic acc;
    int lat;
    int bad = 0;
    logic [127:0] snap;
    logic [127:0] exp;
    out_ready = 1'b0;
    send(128'hdeadbeef_00112233_44556677_8899aabb, 128'h0f0e0d0c_0b0a0908_07060504_03020100,
         1'b0, acc);
    wait_valid(lat);
    snap = out_state;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (out_valid !== 1'b1 || out_state !== snap || in_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL backpressure_hold: unstable cycles=%0d, required 0", bad);
    end
    exp = sb.pop_front();
    checks++;
    if (out_state !== exp) begin
      failures++;
      $display("FAIL backpressure_data: got %h, required %h", out_state, exp);
    end
    out_ready = 1'b1;
    tick;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b, required 1 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [127:0] ds [2];
    logic [127:0] ks [2];
    int acc_cyc [2];
    int nacc = 0;
    int nout = 0;
    logic [127:0] exp;
    ds[0] = 128'h00112233_44556677_8899aabb_ccddeeff;
    ks[0] = 128'h000102030405060708090a0b0c0d0e0f;
    ds[1] = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
    ks[1] = 128'h13111d7f_e3944a17_f307a78b_4d2b30c5;
    out_ready = 1'b1;
    in_bypass_mc = 1'b0;
    in_state = ds[0]; in_key = ks[0]; in_valid = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      logic took = 1'b0;
      if (in_valid && in_ready && nacc < 2) begin
        acc_cyc[nacc] = cyc;
        sb.push_back(model(in_state, in_key, 1'b0));
        nacc++;
        took = 1'b1;
      end
      if (out_valid) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL b2b_unexpected: output %h with empty scoreboard", out_state);
        end else begin
          exp = sb.pop_front();
          if (out_state !== exp) begin
            failures++;
            $display("FAIL b2b_data: got %h, required %h", out_state, exp);
          end
        end
        nout++;
      end
      tick;
      if (took) begin
        if (nacc < 2) begin in_state = ds[nacc]; in_key = ks[nacc]; end
        else in_valid = 1'b0;
      end
    end
    checks++;
    if (nacc != 2 || nout != 2 || acc_cyc[1] - acc_cyc[0] != 6) begin
      failures++;
      $display("FAIL b2b_spacing: accepts=%0d outputs=%0d spacing=%0d, required 2 2 6",
               nacc, nout, (nacc == 2) ? acc_cyc[1] - acc_cyc[0] : -1);
    end
  endtask

  initial begin
    test_reset;
    test_reset_mid_proc;
    test_known_column;
    test_known_column_const;
    test_addkey_mc;
    test_bypass;
    test_random;
    test_backpressure;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
